// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch / PC stage of the 8-bit CPU.
// It reads two-byte instructions (opcode, operand) from a combinational ROM.
// It drives the downstream jump unit and loads that unit's next_pc at the
// end of every EXEC cycle.
module fetch_ctrl #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [7:0] next_pc,
  output logic       jmp_en,
  output logic [2:0] jmp_op,
  output logic [7:0] jmp_addr,
  output logic [7:0] jmp_pc,
  output logic [7:0] ir,
  output logic [7:0] arg,
  output logic       exec_valid,
  output logic       halted
);

  typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, EXEC, HALT} state_t;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] arg_q;
  logic [7:0] jpc_q;
  logic       exec_q;
  logic       jen_q;
  logic       halt_q;

  // Sequencer. Per-state flags are registered on entry, so they are glitch-free.
  // hold freezes everything; rst overrides hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_OP;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      arg_q   <= 8'h00;
      jpc_q   <= 8'h00;
      exec_q  <= 1'b0;
      jen_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else if (!hold) begin
      case (state_q)
        FETCH_OP: begin
          ir_q <= rom_data;
          if (rom_data == HALT_OPCODE) begin
            // PC stays on the halt opcode so rom_addr keeps pointing at it
            state_q <= HALT;
            halt_q  <= 1'b1;
          end else begin
            pc_q    <= pc_q + 8'd1;
            state_q <= FETCH_ARG;
          end
        end
        FETCH_ARG: begin
          arg_q   <= rom_data;
          jpc_q   <= pc_q;             // address of the operand byte
          pc_q    <= pc_q + 8'd1;
          state_q <= EXEC;
          exec_q  <= 1'b1;
          jen_q   <= (ir_q[7:5] == 3'b111);
        end
        EXEC: begin
          // For a non-jump instruction the jump unit returns jmp_pc+1, which equals pc_q.
          // So next_pc is loaded unconditionally.
          pc_q    <= next_pc;
          state_q <= FETCH_OP;
          exec_q  <= 1'b0;
          jen_q   <= 1'b0;
        end
        HALT: state_q <= HALT;
        default: state_q <= FETCH_OP;
      endcase
    end
  end

  assign rom_addr   = pc_q;
  assign jmp_en     = jen_q;
  assign jmp_op     = ir_q[2:0];
  assign jmp_addr   = arg_q;
  assign jmp_pc     = jpc_q;
  assign ir         = ir_q;
  assign arg        = arg_q;
  assign exec_valid = exec_q;
  assign halted     = halt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl. An instruction-level model expands each instruction
// into its expected per-cycle bus view. Cycles that are held do not advance
// that view. A small behavioural jump unit supplies next_pc.
module tb_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst, hold;
  logic [7:0] rom_addr, rom_data, next_pc, jmp_addr, jmp_pc, ir, arg;
  logic [2:0] jmp_op;
  logic       jmp_en, exec_valid, halted;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .hold(hold), .rom_addr(rom_addr), .rom_data(rom_data),
    .next_pc(next_pc), .jmp_en(jmp_en), .jmp_op(jmp_op), .jmp_addr(jmp_addr),
    .jmp_pc(jmp_pc), .ir(ir), .arg(arg), .exec_valid(exec_valid), .halted(halted)
  );

  typedef struct {
    logic [7:0] addr;
    bit         ev, je, hl, full;
    logic [2:0] op;
    logic [7:0] ja, jpc, ir, arg;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mpc;
  bit         zf, zf_rand;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Jump unit condition: op 0 always; odd ops need zf set; other even ops need zf clear.
  function automatic bit taken(input logic [2:0] op, input bit z);
    if (op == 3'd0) return 1'b1;
    else if (op[0]) return z;
    else return !z;
  endfunction

  // Expand the instruction at the model PC into its per-cycle expectations.
  task automatic gen();
    exp_t       e;
    logic [7:0] op, a;
    op = rom[mpc];
    if (zf_rand) zf = ($urandom_range(0, 1) == 1);
    e = '{default: '0};
    e.addr = mpc;
    q.push_back(e);
    if (op == 8'hFF) begin
      e.hl = 1'b1;
      e.ir = op;
      q.push_back(e);                  // sticky: never popped
    end else begin
      a = rom[mpc + 8'd1];
      e.addr = mpc + 8'd1;
      q.push_back(e);
      e.addr = mpc + 8'd2;
      e.ev   = 1'b1;
      e.je   = (op[7:5] == 3'b111);
      e.full = 1'b1;
      e.op   = op[2:0];
      e.ja   = a;
      e.jpc  = mpc + 8'd1;
      e.ir   = op;
      e.arg  = a;
      q.push_back(e);
      mpc = (e.je && taken(op[2:0], zf)) ? a : mpc + 8'd2;
    end
  endtask

  // One clock: check at negedge, act as jump unit, then cross the posedge with hold=h.
  task automatic cycle(input bit h);
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) gen();
    e = q[0];
    chk("rom_addr", rom_addr, e.addr);
    chk("exec_valid", exec_valid, e.ev);
    chk("jmp_en", jmp_en, e.je);
    chk("halted", halted, e.hl);
    if (e.full) begin
      chk("jmp_op", jmp_op, e.op);
      chk("jmp_addr", jmp_addr, e.ja);
      chk("jmp_pc", jmp_pc, e.jpc);
      chk("ir", ir, e.ir);
      chk("arg", arg, e.arg);
    end
    if (e.hl) chk("ir_halt", ir, e.ir);
    hold    = h;
    next_pc = (jmp_en && taken(jmp_op, zf)) ? jmp_addr : jmp_pc + 8'd1;
    @(posedge clk);
    if (!h && !q[0].hl) void'(q.pop_front());
  endtask

  // Asynchronous reset pulse between edges. It checks the outputs right away,
  // then releases after one posedge with rst still asserted.
  task automatic do_reset(input bit h);
    #2;
    rst  = 1'b1;
    hold = h;
    #1;
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_jmp_en", jmp_en, 1'b0);
    chk("rst_exec_valid", exec_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_jmp_op", jmp_op, 3'd0);
    chk("rst_jmp_addr", jmp_addr, 8'h00);
    chk("rst_jmp_pc", jmp_pc, 8'h00);
    chk("rst_ir", ir, 8'h00);
    chk("rst_arg", arg, 8'h00);
    q.delete();
    mpc = 8'h00;
    @(posedge clk);
    #2;
    rst  = 1'b0;
    hold = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic linear_rom();
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h22; rom[8'h02] = 8'h11; rom[8'h03] = 8'h33;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; next_pc = 8'h00; zf = 1'b0; zf_rand = 1'b0; mpc = 8'h00;
    clear_rom();

    // Linear flow
    linear_rom();
    do_reset(1'b0);
    repeat (9) cycle(1'b0);

    // Hold for two cycles in the first EXEC
    do_reset(1'b0);
    cycle(1'b0); cycle(1'b0); cycle(1'b1); cycle(1'b1);
    repeat (6) cycle(1'b0);

    // Unconditional jump, then conditional not taken, then halt; reset applied together with hold
    clear_rom();
    rom[8'h00] = 8'hE0; rom[8'h01] = 8'h40;
    rom[8'h40] = 8'hE0; rom[8'h41] = 8'h05;
    rom[8'h05] = 8'hE1; rom[8'h06] = 8'h12;
    rom[8'h07] = 8'hFF;
    zf = 1'b0;
    do_reset(1'b1);
    repeat (14) cycle(1'b0);

    // Wrap-around: opcode at FF, operand at 00
    clear_rom();
    rom[8'h00] = 8'h55; rom[8'h02] = 8'hE0; rom[8'h03] = 8'hFF; rom[8'hFF] = 8'h10;
    do_reset(1'b0);
    repeat (16) cycle(1'b0);

    // Halt at address 02
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h22; rom[8'h02] = 8'hFF;
    do_reset(1'b0);
    repeat (8) cycle(1'b0);

    // Reset asserted mid-FETCH_ARG, then mid-EXEC
    linear_rom();
    do_reset(1'b0);
    cycle(1'b0);
    do_reset(1'b0);
    cycle(1'b0); cycle(1'b0);
    do_reset(1'b0);
    repeat (7) cycle(1'b0);

    // Randomized programs, hold and flags, with occasional mid-run reset
    zf_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i] = 8'($urandom);
        if (rom[i] == 8'hFF && $urandom_range(0, 3) != 0) rom[i] = 8'h7F;
      end
      do_reset($urandom_range(0, 1) == 1);
      for (int c = 0, n = $urandom_range(20, 150); c < n; c++) begin
        cycle($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 60) == 0) do_reset(1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
